// File: rtl/vit_pkg.sv
// Shared Viterbi decoder definitions: size limits, branch-metric width helper,
// soft-value and decision-mode types.
package vit_pkg;

  localparam int N_OUT_MAX    = 4;
  localparam int Q_MAX        = 6;
  localparam int PUNC_LEN_MAX = 8;

  typedef logic [Q_MAX-1:0] soft_val_t;

  typedef enum logic {
    BM_HARD = 1'b0,
    BM_SOFT = 1'b1
  } bm_mode_t;

  // Width of one branch metric; it must hold n * (2^q - 1).
  function automatic int bm_width(input int n, input int q);
    return q + $clog2(n);
  endfunction

endpackage

// File: rtl/bm_dist_sum.sv
// Distance from one received symbol to a single codeword CW, summed over all
// code outputs. Erased positions contribute nothing.
module bm_dist_sum
  import vit_pkg::*;
#(
  parameter int N_OUT = 2,
  parameter int Q     = 3,
  parameter int BMW   = 4,
  parameter int CW    = 0
) (
  input  logic [N_OUT*Q-1:0] rx,
  input  bm_mode_t           mode,
  input  logic [N_OUT-1:0]   keep,
  output logic [BMW-1:0]     metric
);

  localparam logic [N_OUT-1:0] CW_BITS = N_OUT'(CW);

  always_comb begin
    logic [Q-1:0] r;
    logic [Q-1:0] d;
    r      = '0;
    d      = '0;
    metric = '0;
    for (int j = 0; j < N_OUT; j++) begin
      r = rx[j*Q +: Q];
      d = '0;
      if (keep[j]) begin
        // In offset binary, 2^Q-1 - r is simply the bitwise complement.
        if (mode == BM_SOFT) d = CW_BITS[j] ? ~r : r;
        else                 d[0] = r[Q-1] ^ CW_BITS[j];
      end
      metric = metric + BMW'(d);
    end
  end

endmodule

// File: rtl/bm_unit_param.sv
// Parametrised branch metric unit: depuncture, hard/soft distance to all
// 2^N_OUT codewords, two-stage back-pressured pipeline.
module bm_unit_param
  import vit_pkg::*;
#(
  parameter  int N_OUT    = 2,
  parameter  int Q        = 3,
  parameter  int PUNC_LEN = 1,
  localparam int BMW      = bm_width(N_OUT, Q),
  localparam int NCW      = 2**N_OUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_OUT*Q-1:0]        i_rx,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_sof,
  input  logic                      i_mode,
  input  logic [PUNC_LEN*N_OUT-1:0] i_punc_mask,
  output logic [NCW*BMW-1:0]        o_bm,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [15:0]               o_sym_cnt
);

  localparam int PW = $clog2(PUNC_LEN_MAX);

  logic               rst_done;
  logic               s1_valid, s2_valid;
  logic               s1_adv, s2_adv, accept;
  logic [N_OUT*Q-1:0] s1_rx;
  bm_mode_t           s1_mode;
  logic [N_OUT-1:0]   s1_keep, keep_sel;
  logic [PW-1:0]      phase, phase_base, phase_nxt;
  logic [NCW*BMW-1:0] bm_nxt;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A stage advances when it is empty or its consumer takes its content.
  assign s2_adv  = !s2_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = s1_adv && rst_done;
  assign accept  = i_valid && o_ready;
  assign o_valid = s2_valid;

  always_comb begin
    phase_base = i_sof ? '0 : phase;
    phase_nxt  = (phase_base == PW'(PUNC_LEN-1)) ? '0 : phase_base + 1'b1;
    keep_sel   = i_punc_mask[phase_base*N_OUT +: N_OUT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done  <= 1'b0;
      phase     <= '0;
      o_sym_cnt <= '0;
    end else begin
      rst_done <= 1'b1;
      if (accept) begin
        phase     <= phase_nxt;
        o_sym_cnt <= i_sof ? 16'd1 :
                     (o_sym_cnt == 16'hFFFF) ? o_sym_cnt : o_sym_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rx    <= '0;
      s1_mode  <= BM_HARD;
      s1_keep  <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_rx   <= i_rx;
        s1_mode <= bm_mode_t'(i_mode);
        s1_keep <= keep_sel;
      end
    end
  end

  for (genvar c = 0; c < NCW; c++) begin : g_cw
    bm_dist_sum #(
      .N_OUT (N_OUT),
      .Q     (Q),
      .BMW   (BMW),
      .CW    (c)
    ) u_dist (
      .rx     (s1_rx),
      .mode   (s1_mode),
      .keep   (s1_keep),
      .metric (bm_nxt[c*BMW +: BMW])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      o_bm     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) o_bm <= bm_nxt;
    end
  end

endmodule

// File: tb/tb_bm_unit_param.sv
// Directed bench for bm_unit_param: a 2-output/3-bit/period-2 instance and a
// 4-output/6-bit unpunctured instance for the metric extremes.
module tb_bm_unit_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0]   i_rx_a;
  logic         i_valid_a, o_ready_a, i_sof_a, i_mode_a, o_valid_a, i_ready_a;
  logic [3:0]   i_punc_mask_a;
  logic [15:0]  o_bm_a, o_sym_cnt_a;

  logic [23:0]  i_rx_b;
  logic         i_valid_b, o_ready_b, i_sof_b, i_mode_b, o_valid_b, i_ready_b;
  logic [3:0]   i_punc_mask_b;
  logic [127:0] o_bm_b;
  logic [15:0]  o_sym_cnt_b;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  bm_unit_param #(.N_OUT(2), .Q(3), .PUNC_LEN(2)) dut_a (
    .clk (clk), .rst (rst), .i_rx (i_rx_a), .i_valid (i_valid_a), .o_ready (o_ready_a),
    .i_sof (i_sof_a), .i_mode (i_mode_a), .i_punc_mask (i_punc_mask_a), .o_bm (o_bm_a),
    .o_valid (o_valid_a), .i_ready (i_ready_a), .o_sym_cnt (o_sym_cnt_a)
  );

  bm_unit_param #(.N_OUT(4), .Q(6), .PUNC_LEN(1)) dut_b (
    .clk (clk), .rst (rst), .i_rx (i_rx_b), .i_valid (i_valid_b), .o_ready (o_ready_b),
    .i_sof (i_sof_b), .i_mode (i_mode_b), .i_punc_mask (i_punc_mask_b), .o_bm (o_bm_b),
    .o_valid (o_valid_b), .i_ready (i_ready_b), .o_sym_cnt (o_sym_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bm_a(input logic [3:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  // Soft metrics for Q=3, nothing erased.
  function automatic logic [15:0] soft_model(input int r0, input int r1);
    return bm_a(4'(r0 + r1), 4'(7 - r0 + r1), 4'(r0 + 7 - r1), 4'(14 - r0 - r1));
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic apply_a(input logic [2:0] r0, input logic [2:0] r1, input logic mode,
                         input logic sof, input logic [15:0] exp, input string tag);
    i_rx_a = {r1, r0}; i_mode_a = mode; i_sof_a = sof; i_valid_a = 1'b1;
    #1 check({tag, " ready"}, o_ready_a, 1);
    @(negedge clk);
    i_valid_a = 1'b0; i_sof_a = 1'b0;
    check({tag, " latency"}, o_valid_a, 0);
    @(negedge clk);
    check({tag, " valid"}, o_valid_a, 1);
    check({tag, " bm"}, o_bm_a, exp);
    @(negedge clk);
    check({tag, " drop"}, o_valid_a, 0);
  endtask

  initial begin
    int sent = 0;
    int got = 0;
    int stall_left = 0;
    bit seen = 1'b0;
    bit prev_stall = 1'b0;
    logic [15:0] prev_bm = '0;

    rst = 1'b1;
    i_rx_a = '0; i_valid_a = 0; i_sof_a = 0; i_mode_a = 0; i_punc_mask_a = 4'b1111; i_ready_a = 1;
    i_rx_b = '0; i_valid_b = 0; i_sof_b = 0; i_mode_b = 0; i_punc_mask_b = 4'hF;    i_ready_b = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst o_valid", o_valid_a, 0);
    check("rst o_bm", o_bm_a, 0);
    check("rst sym_cnt", o_sym_cnt_a, 0);
    check("rst o_ready", o_ready_a, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst o_ready", o_ready_a, 1);

    apply_a(3'd7, 3'd0, 1'b1, 1'b1, bm_a(7, 0, 14, 7), "soft 7,0");
    apply_a(3'd7, 3'd0, 1'b0, 1'b0, bm_a(1, 0, 2, 1),  "hard 7,0");
    apply_a(3'd3, 3'd4, 1'b0, 1'b0, bm_a(1, 2, 0, 1),  "hard 3,4");
    check("sym_cnt after 3", o_sym_cnt_a, 3);

    i_punc_mask_a = 4'b0111;
    apply_a(3'd7, 3'd7, 1'b1, 1'b1, bm_a(14, 7, 7, 0), "punc sym0");
    apply_a(3'd7, 3'd7, 1'b1, 1'b0, bm_a(7, 0, 7, 0),  "punc sym1");
    apply_a(3'd7, 3'd7, 1'b1, 1'b0, bm_a(14, 7, 7, 0), "punc wrap");
    apply_a(3'd7, 3'd7, 1'b1, 1'b1, bm_a(14, 7, 7, 0), "punc sof mid");
    apply_a(3'd7, 3'd7, 1'b1, 1'b0, bm_a(7, 0, 7, 0),  "punc after sof");
    check("sym_cnt after sof", o_sym_cnt_a, 2);

    // Back-pressure: 5 symbols streamed, 4-cycle stall from the first result.
    i_punc_mask_a = 4'b1111;
    i_mode_a = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      if (o_valid_a && !seen) begin
        seen = 1'b1;
        stall_left = 4;
      end
      i_ready_a = (stall_left == 0);
      i_valid_a = (sent < 5);
      i_sof_a   = (sent == 0);
      i_rx_a    = {3'd0, 3'(sent + 1)};
      #1;
      if (prev_stall) begin
        check("stall bm hold", o_bm_a, prev_bm);
        check("stall valid hold", o_valid_a, 1);
      end
      if (stall_left == 4) begin
        check("bp o_ready low", o_ready_a, 0);
        check("bp buffered", sent, 2);
      end
      if (o_valid_a && i_ready_a) begin
        check("bp result expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("bp result", o_bm_a, exp_q.pop_front());
        got++;
      end
      if (i_valid_a && o_ready_a) begin
        exp_q.push_back(soft_model(sent + 1, 0));
        sent++;
      end
      prev_stall = o_valid_a && !i_ready_a;
      prev_bm    = o_bm_a;
      if (stall_left > 0) stall_left--;
    end
    i_valid_a = 1'b0; i_sof_a = 1'b0; i_ready_a = 1'b1;
    check("bp delivered", got, 5);
    check("bp queue empty", exp_q.size(), 0);
    check("bp sym_cnt", o_sym_cnt_a, 5);
    @(negedge clk);
    check("bp no duplicate", o_valid_a, 0);

    // Reset with both stages full.
    i_ready_a = 1'b0; i_mode_a = 1'b1; i_rx_a = {3'd2, 3'd5}; i_valid_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_valid_a = 1'b0;
    check("fill o_valid", o_valid_a, 1);
    check("fill o_ready", o_ready_a, 0);
    #2 rst = 1'b1;
    #1;
    check("async rst o_valid", o_valid_a, 0);
    check("async rst o_bm", o_bm_a, 0);
    check("async rst sym_cnt", o_sym_cnt_a, 0);
    @(negedge clk);
    rst = 1'b0; i_ready_a = 1'b1;
    @(negedge clk);
    check("rerun o_ready", o_ready_a, 1);
    check("rerun no stale", o_valid_a, 0);
    apply_a(3'd0, 3'd7, 1'b1, 1'b0, bm_a(7, 14, 0, 7), "rerun soft 0,7");
    check("rerun sym_cnt", o_sym_cnt_a, 1);

    // Extremes on the 4-output, 6-bit instance.
    i_rx_b = '1; i_mode_b = 1'b1; i_valid_b = 1'b1;
    @(negedge clk);
    i_valid_b = 1'b0;
    @(negedge clk);
    check("ext soft valid", o_valid_b, 1);
    check("ext soft c0", o_bm_b[7:0], 252);
    check("ext soft c5", o_bm_b[47:40], 126);
    check("ext soft c15", o_bm_b[127:120], 0);
    i_mode_b = 1'b0; i_valid_b = 1'b1;
    @(negedge clk);
    i_valid_b = 1'b0;
    @(negedge clk);
    check("ext hard c0", o_bm_b[7:0], 4);
    check("ext hard c5", o_bm_b[47:40], 2);
    check("ext hard c15", o_bm_b[127:120], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
